// File: rtl/mem60k_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem60k_arbiter_if
// Brief    : Request/response bundle for the two arbiter ports plus the RAM side.
// Revision : 1.0 - initial release
// ============================================================================
interface mem60k_arbiter_if #(
   parameter int ADDR_W = 14
);
   // Port A: CPU-side valid/ready with byte strobes
   logic              a_valid;
   logic [ADDR_W-1:0] a_addr;
   logic [31:0]       a_wdata;
   logic [3:0]        a_wstrb;
   logic              a_ready;
   logic [31:0]       a_rdata;
   logic              a_err;

   // Port B: auxiliary full-word port
   logic              b_valid;
   logic [ADDR_W-1:0] b_addr;
   logic [31:0]       b_wdata;
   logic              b_write;
   logic              b_ready;
   logic [31:0]       b_rdata;
   logic              b_err;

   // Single-cycle-latency synchronous RAM
   logic              ram_en;
   logic              ram_write;
   logic [ADDR_W-1:0] ram_addr;
   logic [31:0]       ram_wdata;
   logic [31:0]       ram_rdata;

   // Arbiter side
   modport slave (
      input  a_valid, a_addr, a_wdata, a_wstrb,
      output a_ready, a_rdata, a_err,
      input  b_valid, b_addr, b_wdata, b_write,
      output b_ready, b_rdata, b_err,
      output ram_en, ram_write, ram_addr, ram_wdata,
      input  ram_rdata
   );

   // Requester / RAM-model side
   modport master (
      output a_valid, a_addr, a_wdata, a_wstrb,
      input  a_ready, a_rdata, a_err,
      output b_valid, b_addr, b_wdata, b_write,
      input  b_ready, b_rdata, b_err,
      input  ram_en, ram_write, ram_addr, ram_wdata,
      output ram_rdata
   );
endinterface
`default_nettype wire

// File: rtl/mem60k_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem60k_arbiter
// Brief    : Round-robin two-port arbiter for the 12288x32 word store; turns
//            partial-strobe writes into read-modify-write sequences.
// Revision : 1.0 - initial release
// ============================================================================
module mem60k_arbiter #(
   parameter int ADDR_W = 14,
   parameter int DEPTH  = 12288
) (
   input  logic                  clk,
   input  logic                  reset,
   mem60k_arbiter_if.slave       bus
);

   localparam logic [ADDR_W:0] c_depth     = (ADDR_W+1)'(DEPTH);
   localparam logic [3:0]      c_strb_full = 4'hF;
   localparam logic [3:0]      c_strb_read = 4'h0;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ACCESS = 3'd1,
      S_WAIT   = 3'd2,
      S_MERGE  = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   state_t            r_state;
   state_t            w_state_next;

   // r_port / r_last_grant: 0 = port A, 1 = port B
   logic              r_port;
   logic              r_last_grant;
   logic              r_err;
   logic [ADDR_W-1:0] r_addr;
   logic [31:0]       r_wdata;
   logic [3:0]        r_strb;
   logic [31:0]       r_a_rdata;
   logic [31:0]       r_b_rdata;

   logic              w_any;
   logic              w_grant_b;
   logic [ADDR_W-1:0] w_sel_addr;
   logic [31:0]       w_sel_wdata;
   logic [3:0]        w_sel_strb;
   logic              w_oor;
   logic              w_full;
   logic              w_read;
   logic [31:0]       w_merged;

   // Request selection, evaluated only while IDLE
   always_comb begin
      w_any       = bus.a_valid | bus.b_valid;
      w_grant_b   = bus.b_valid & (~bus.a_valid | ~r_last_grant);
      w_sel_addr  = w_grant_b ? bus.b_addr  : bus.a_addr;
      w_sel_wdata = w_grant_b ? bus.b_wdata : bus.a_wdata;
      w_sel_strb  = w_grant_b ? (bus.b_write ? c_strb_full : c_strb_read) : bus.a_wstrb;
      w_oor       = ({1'b0, w_sel_addr} >= c_depth);
   end

   assign w_full = (r_strb == c_strb_full);
   assign w_read = (r_strb == c_strb_read);

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_merge
         assign w_merged[8*gi +: 8] = r_strb[gi] ? r_wdata[8*gi +: 8]
                                                 : bus.ram_rdata[8*gi +: 8];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_any) begin
               w_state_next = w_oor ? S_DONE : S_ACCESS;
            end
         end
         S_ACCESS: w_state_next = w_full ? S_DONE : S_WAIT;
         S_WAIT:   w_state_next = w_read ? S_DONE : S_MERGE;
         S_MERGE:  w_state_next = S_DONE;
         S_DONE:   w_state_next = S_IDLE;
         default:  w_state_next = S_IDLE;
      endcase
   end

   // Latched request fields and per-port response registers.
   // Response registers load on entry to DONE so data is valid with ready.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_port       <= 1'b0;
         r_last_grant <= 1'b1;
         r_err        <= 1'b0;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_strb       <= '0;
         r_a_rdata    <= '0;
         r_b_rdata    <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_port       <= w_grant_b;
                  r_last_grant <= w_grant_b;
                  r_addr       <= w_sel_addr;
                  r_wdata      <= w_sel_wdata;
                  r_strb       <= w_sel_strb;
                  r_err        <= w_oor;
                  if (w_oor && (w_sel_strb == c_strb_read)) begin
                     if (w_grant_b) begin
                        r_b_rdata <= '0;
                     end else begin
                        r_a_rdata <= '0;
                     end
                  end
               end
            end
            S_WAIT: begin
               if (w_read) begin
                  if (r_port) begin
                     r_b_rdata <= bus.ram_rdata;
                  end else begin
                     r_a_rdata <= bus.ram_rdata;
                  end
               end else begin
                  // The merged word replaces the write data for the MERGE cycle
                  r_wdata <= w_merged;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.a_ready   = (r_state == S_DONE) & ~r_port;
   assign bus.b_ready   = (r_state == S_DONE) &  r_port;
   assign bus.a_err     = (r_state == S_DONE) & ~r_port & r_err;
   assign bus.b_err     = (r_state == S_DONE) &  r_port & r_err;
   assign bus.a_rdata   = r_a_rdata;
   assign bus.b_rdata   = r_b_rdata;

   assign bus.ram_en    = (r_state == S_ACCESS) | (r_state == S_MERGE);
   assign bus.ram_write = ((r_state == S_ACCESS) & w_full) | (r_state == S_MERGE);
   assign bus.ram_addr  = r_addr;
   assign bus.ram_wdata = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem60k_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem60k_arbiter
// Brief    : Self-checking bench: RAM model, transaction-level reference model,
//            directed scenarios and randomized two-port traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem60k_arbiter;

   localparam int c_depth = 12288;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   mem60k_arbiter_if #(.ADDR_W(14)) bus ();

   mem60k_arbiter #(.ADDR_W(14), .DEPTH(c_depth)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int a_start = 0;
   int b_start = 0;
   int a_pulses = 0;
   int grant_order[$];
   bit model_on = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] init_word(input int i);
      if (i == 5) return 32'h11223344;
      if (i == 7) return 32'h01020304;
      return {16'(i) ^ 16'h5A5A, ~16'(i)};
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                         input logic [3:0] strb);
      logic [31:0] m;
      for (int i = 0; i < 4; i++) m[8*i +: 8] = strb[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
      return m;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Single-cycle-latency RAM standing in for the data store
   logic [31:0] ram [0:c_depth-1];
   bit ram_loaded = 1'b0;
   always @(posedge clk) begin
      if (!ram_loaded) begin
         for (int i = 0; i < c_depth; i++) ram[i] = init_word(i);
         ram_loaded = 1'b1;
      end
      if (bus.ram_en && (int'(bus.ram_addr) < c_depth)) begin
         if (bus.ram_write) ram[bus.ram_addr] = bus.ram_wdata;
         else               bus.ram_rdata <= ram[bus.ram_addr];
      end
   end

   // Reference model: each grant is a transaction with a fixed latency;
   // RAM activity is expected at fixed offsets from the sampling cycle.
   logic [31:0] ref_mem [0:c_depth-1];
   bit          ref_init = 1'b0;
   int          off = -1;
   int          lat_m = 0;
   bit          cport = 1'b0;
   bit          last_b = 1'b1;
   logic [13:0] caddr = '0;
   logic [31:0] cwdata = '0;
   logic [3:0]  cstrb = '0;
   bit          coor = 1'b0;
   logic [31:0] exp_ard = '0;
   logic [31:0] exp_brd = '0;

   always @(negedge clk) begin
      bit e_ar, e_br, e_en, e_we, full, part, rd;
      logic [31:0] e_wd;
      if (model_on) begin
         if (!ref_init) begin
            for (int i = 0; i < c_depth; i++) ref_mem[i] = init_word(i);
            ref_init = 1'b1;
         end
         rd   = (cstrb == 4'h0);
         full = !coor && (cstrb == 4'hF);
         part = !coor && !rd && (cstrb != 4'hF);
         e_ar = (off > 0) && (off == lat_m) && !cport;
         e_br = (off > 0) && (off == lat_m) &&  cport;
         e_en = (off == 1 && !coor) || (off == 3 && part);
         e_we = (off == 1 && full)  || (off == 3 && part);
         e_wd = full ? cwdata : merge(ref_mem[caddr], cwdata, cstrb);
         if ((e_ar || e_br) && rd) begin
            if (cport) exp_brd = coor ? 32'h0 : ref_mem[caddr];
            else       exp_ard = coor ? 32'h0 : ref_mem[caddr];
         end
         if (bus.a_ready) a_pulses++;
         chk("a_ready",   bus.a_ready,   e_ar);
         chk("b_ready",   bus.b_ready,   e_br);
         chk("a_err",     bus.a_err,     e_ar && coor);
         chk("b_err",     bus.b_err,     e_br && coor);
         chk("ram_en",    bus.ram_en,    e_en);
         chk("ram_write", bus.ram_write, e_we);
         chk("a_rdata",   bus.a_rdata,   exp_ard);
         chk("b_rdata",   bus.b_rdata,   exp_brd);
         if (e_en) chk("ram_addr",  bus.ram_addr,  caddr);
         if (e_we) begin
            chk("ram_wdata", bus.ram_wdata, e_wd);
            ref_mem[caddr] = e_wd;
         end
         if (reset) begin
            off = -1; last_b = 1'b1; exp_ard = '0; exp_brd = '0;
         end else if (off < 0) begin
            if (bus.a_valid || bus.b_valid) begin
               cport  = bus.b_valid && (!bus.a_valid || !last_b);
               last_b = cport;
               caddr  = cport ? bus.b_addr  : bus.a_addr;
               cwdata = cport ? bus.b_wdata : bus.a_wdata;
               cstrb  = cport ? (bus.b_write ? 4'hF : 4'h0) : bus.a_wstrb;
               coor   = int'(caddr) >= c_depth;
               lat_m  = coor ? 1 : (cstrb == 4'hF) ? 2 : (cstrb == 4'h0) ? 3 : 4;
               off    = 1;
            end
         end else if (off == lat_m) begin
            off = -1;
         end else begin
            off++;
         end
      end
   end

   task automatic start_a(input logic [13:0] addr, input logic [31:0] d, input logic [3:0] s);
      bus.a_addr = addr; bus.a_wdata = d; bus.a_wstrb = s; bus.a_valid = 1'b1; a_start = cyc;
   endtask

   task automatic start_b(input logic [13:0] addr, input logic [31:0] d, input logic w);
      bus.b_addr = addr; bus.b_wdata = d; bus.b_write = w; bus.b_valid = 1'b1; b_start = cyc;
   endtask

   task automatic await_a(output int lat, output logic [31:0] rdat, output logic err);
      bit got = 1'b0;
      lat = -1; rdat = '0; err = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         if (bus.a_ready) got = 1'b1;
      end
      if (!got) begin
         checks++; failures++;
         $display("FAIL a_timeout actual=no_ready required=ready_within_40_cycles");
      end else begin
         lat = cyc - a_start; rdat = bus.a_rdata; err = bus.a_err;
         grant_order.push_back(0);
      end
      @(posedge clk); #1;
      bus.a_valid = 1'b0;
   endtask

   task automatic await_b(output int lat, output logic [31:0] rdat, output logic err);
      bit got = 1'b0;
      lat = -1; rdat = '0; err = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         if (bus.b_ready) got = 1'b1;
      end
      if (!got) begin
         checks++; failures++;
         $display("FAIL b_timeout actual=no_ready required=ready_within_40_cycles");
      end else begin
         lat = cyc - b_start; rdat = bus.b_rdata; err = bus.b_err;
         grant_order.push_back(1);
      end
      @(posedge clk); #1;
      bus.b_valid = 1'b0;
   endtask

   task automatic do_a(input logic [13:0] addr, input logic [31:0] d, input logic [3:0] s,
                       output int lat, output logic [31:0] rdat, output logic err);
      @(posedge clk); #1;
      start_a(addr, d, s);
      await_a(lat, rdat, err);
   endtask

   task automatic do_b(input logic [13:0] addr, input logic [31:0] d, input logic w,
                       output int lat, output logic [31:0] rdat, output logic err);
      @(posedge clk); #1;
      start_b(addr, d, w);
      await_b(lat, rdat, err);
   endtask

   function automatic logic [13:0] rnd_addr();
      int r = int'($urandom_range(0, 9));
      if (r < 7) return 14'($urandom_range(0, 31));
      if (r < 9) return 14'(c_depth - 2 + int'($urandom_range(0, 3)));
      return 14'($urandom_range(0, 16383));
   endfunction

   function automatic logic [3:0] rnd_strb();
      int k = int'($urandom_range(0, 2));
      if (k == 0) return 4'h0;
      if (k == 1) return 4'hF;
      return 4'($urandom_range(0, 15));
   endfunction

   initial begin
      int lat, lat2, pulses0;
      logic [31:0] rdat, rdat2;
      logic err, err2;
      bus.a_valid = 1'b0; bus.a_addr = '0; bus.a_wdata = '0; bus.a_wstrb = '0;
      bus.b_valid = 1'b0; bus.b_addr = '0; bus.b_wdata = '0; bus.b_write = 1'b0;

      // Reset with both ports requesting; A must win the first contention
      @(posedge clk); #1;
      model_on = 1'b1;
      start_a(14'd3, 32'h0, 4'h0);
      start_b(14'd4, 32'h0, 1'b0);
      repeat (2) begin
         @(negedge clk);
         chk("rst_a_ready", bus.a_ready, 1'b0);
         chk("rst_ram_en",  bus.ram_en,  1'b0);
         chk("rst_a_rdata", bus.a_rdata, 32'h0);
         chk("rst_ram_addr", bus.ram_addr, 14'h0);
         chk("rst_ram_wdata", bus.ram_wdata, 32'h0);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      grant_order.delete();
      fork
         await_a(lat, rdat, err);
         await_b(lat2, rdat2, err2);
      join
      chk("first_grant_is_a", grant_order.size() > 0 ? grant_order[0] : 9, 0);
      chk("rst_read3", rdat, init_word(3));

      // Full write then read back
      do_a(14'h10, 32'hDEADBEEF, 4'hF, lat, rdat, err);
      chk("full_write_latency", lat, 2);
      do_a(14'h10, 32'h0, 4'h0, lat, rdat, err);
      chk("read_latency", lat, 3);
      chk("read_back", rdat, 32'hDEADBEEF);

      // Partial write becomes read-modify-write
      do_a(14'd5, 32'hAABBCCDD, 4'b0101, lat, rdat, err);
      chk("rmw_latency", lat, 4);
      do_b(14'd5, 32'h0, 1'b0, lat, rdat, err);
      chk("rmw_result", rdat, 32'h11BB33DD);

      // Contention alternates A,B,A,B
      grant_order.delete();
      fork
         begin
            int l; logic [31:0] r; logic e;
            for (int i = 0; i < 4; i++) do_a(14'(20 + i), 32'h0, 4'h0, l, r, e);
         end
         begin
            int l; logic [31:0] r; logic e;
            for (int i = 0; i < 4; i++) do_b(14'(24 + i), 32'h0, 1'b0, l, r, e);
         end
      join
      chk("contention_count", grant_order.size(), 8);
      for (int i = 0; i < 8 && i < grant_order.size(); i++)
         chk("contention_order", grant_order[i], i % 2);

      // Out-of-range boundary
      do_b(14'd12288, 32'h0, 1'b0, lat, rdat, err);
      chk("oor_latency", lat, 1);
      chk("oor_err", err, 1'b1);
      chk("oor_rdata", rdat, 32'h0);
      do_b(14'd12287, 32'h0, 1'b0, lat, rdat, err);
      chk("last_word_err", err, 1'b0);
      chk("last_word_latency", lat, 3);
      chk("last_word_rdata", rdat, init_word(12287));

      // Reset during WAIT of a partial write abandons it
      pulses0 = a_pulses;
      @(posedge clk); #1;
      start_a(14'd7, 32'hFFFFFFFF, 4'b0011);
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b1; bus.a_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (3) @(posedge clk);
      chk("abandoned_no_ready", a_pulses, pulses0);
      do_a(14'd7, 32'h0, 4'h0, lat, rdat, err);
      chk("abandoned_ram_kept", rdat, 32'h01020304);

      // Randomized two-port traffic
      fork
         begin
            int l; logic [31:0] r; logic e;
            for (int i = 0; i < 80; i++) begin
               repeat ($urandom_range(0, 2)) @(posedge clk);
               do_a(rnd_addr(), $urandom, rnd_strb(), l, r, e);
            end
         end
         begin
            int l; logic [31:0] r; logic e;
            for (int i = 0; i < 80; i++) begin
               repeat ($urandom_range(0, 2)) @(posedge clk);
               do_b(rnd_addr(), $urandom, 1'($urandom_range(0, 1)), l, r, e);
            end
         end
      join

      repeat (4) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=still_running required=finished");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire

// File: doc/mem60k_arbiter.md
# mem60k_arbiter

Two-port arbiter and access sequencer for the 12288×32 `memory_60kb` data store. It shares the store between:
- the CPU-side port (port A), which uses the PicoRV32-style valid/ready protocol with byte strobes;
- an auxiliary full-word port (port B), used for display or cache-walker logic.

The block grants one request at a time round-robin. Because the RAM only supports word writes, it turns partial-strobe writes into read-modify-write sequences. It drives the RAM's single-cycle-latency synchronous interface.

## Interface

Parameters:
- `ADDR_W`, 14, word-address width.
- `DEPTH`, 12288, number of valid words. Addresses `>= DEPTH` are out of range.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `a_valid` in 1: port A request.
- `a_addr` in `ADDR_W`: port A word address.
- `a_wdata` in 32: port A write data.
- `a_wstrb` in 4: port A byte strobes; `4'h0` = read.
- `a_ready` out 1: one-cycle completion pulse for port A.
- `a_rdata` out 32: port A read data, valid while `a_ready` is high, held otherwise.
- `a_err` out 1: high with `a_ready` when the address was out of range.
- `b_valid` in 1: port B request.
- `b_addr` in `ADDR_W`: port B word address.
- `b_wdata` in 32: port B write data.
- `b_write` in 1: 1 = full-word write, 0 = read.
- `b_ready` out 1: completion pulse for port B.
- `b_rdata` out 32: port B read data.
- `b_err` out 1: out-of-range flag for port B.
- `ram_en` out 1: RAM enable.
- `ram_write` out 1: RAM write enable.
- `ram_addr` out `ADDR_W`: RAM address.
- `ram_wdata` out 32: RAM write data.
- `ram_rdata` in 32: RAM read data, valid the cycle after an enabled read.

## Operation

States: IDLE, ACCESS, WAIT, MERGE, DONE.
- **IDLE**
  - If any valid is high, select a winner and latch `addr`, `wdata`, strobes (port B writes become `4'hF`) and the port id.
  - Arbitration: if only one port requests, it wins. If both request, the port not granted last wins (`last_grant` toggles on each grant).
  - In range: go to ACCESS. Out of range: go straight to DONE with err=1 and rdata=0, with no RAM activity.
- **ACCESS**
  - `ram_en`=1, `ram_addr`=latched address.
  - Full write (strb=`4'hF`): `ram_write`=1, `ram_wdata`=latched data, then go to DONE.
  - Read or partial write: `ram_write`=0, then go to WAIT.
- **WAIT**
  - `ram_en`=0; capture `ram_rdata`.
  - Read: store it as the response, then go to DONE.
  - Partial write: form the merged word (byte i = strb[i] ? wdata byte i : rdata byte i), then go to MERGE.
- **MERGE**: `ram_en`=1, `ram_write`=1, `ram_wdata`=merged word, then go to DONE.
- **DONE**
  - Pulse the granted port's ready for one cycle.
  - On a read, load that port's rdata register; on a write, leave it unchanged.
  - Drive that port's err. Then go to IDLE.
- `ram_*` outputs are decoded from state and the latched fields. `ram_en`=0 and `ram_write`=0 in IDLE, WAIT and DONE.
- A requester holds valid and its request fields stable until its ready pulse, and drops valid in the cycle following ready. The arbiter never re-samples a port during DONE, so a completed request is never issued twice.
- The non-granted port's valid is ignored (held pending) until the arbiter returns to IDLE.

## Timing

Latency, measured from the IDLE cycle in which valid is sampled (cycle 0) to the ready pulse:
- full write: cycle 2;
- read: cycle 3;
- partial write: cycle 4;
- out of range: cycle 1.

Throughput: one request completes per (latency+1) cycles, because IDLE is mandatory between requests.

Reset values:
- `a_ready`, `b_ready`, `a_err`, `b_err`, `ram_en`, `ram_write` = 0;
- `a_rdata`, `b_rdata`, `ram_addr`, `ram_wdata` = 0;
- state = IDLE;
- `last_grant` = B, so port A wins the first contention.

Reset mid-operation: the in-flight request is abandoned with no ready pulse. A partial write interrupted before MERGE leaves the RAM unmodified. `reset` overrides every other input in the same edge.

Address `DEPTH-1` is in range; address `DEPTH` and above is out of range (err).

Simultaneous valid on both ports in consecutive grants alternates A, B, A, B.

## Test plan

- **Reset defaults:** assert `reset` for 2 cycles while `a_valid`=1 → all outputs 0, no `ram_en`; first IDLE after release grants A.
- **Full write then read:** A writes `0x00000010` ← `0xDEADBEEF` with strb `F` → `a_ready` at cycle 2, `ram_write` pulse in ACCESS; A reads `0x10` → `a_ready` at cycle 3 with `a_rdata`=`0xDEADBEEF`.
- **Partial RMW:** RAM[5]=`0x11223344`; A writes `0xAABBCCDD` strb `4'b0101` to 5 → MERGE writes `0x11BB33DD`, `a_ready` at cycle 4; B reads 5 → `b_rdata`=`0x11BB33DD`.
- **Contention:** A and B both valid continuously for 4 requests each → grant order A,B,A,B,…; no ready ever goes to a port that was not granted; `ram_en` is never asserted in IDLE.
- **Out of range:** B reads 12288 → `b_ready` at cycle 1, `b_err`=1, `b_rdata`=0, `ram_en` stays 0; B reads 12287 → `b_err`=0, normal latency.
- **Reset mid-RMW:** partial write to word 7 (RAM=`0x01020304`), reset asserted during WAIT → no ready pulse; a subsequent read of 7 returns `0x01020304`.
